// File: rtl/nco_sweep_ctrl_if.sv
// Handshake/config bundle between a sweep master and nco_sweep_ctrl.
// The master drives configuration and control; the slave returns the NCO drive and status.
interface nco_sweep_ctrl_if #(
   parameter int APR = 32,
   parameter int DWW = 16
);
   logic           cfg_wr;
   logic [APR-1:0] cfg_start;
   logic [APR-1:0] cfg_stop;
   logic [APR-1:0] cfg_step;
   logic [DWW-1:0] cfg_dwell;
   logic           cfg_repeat;
   logic           start;
   logic           abort;
   logic           nco_valid;
   logic [APR-1:0] phi_inc_o;
   logic           nco_clken;
   logic           busy;
   logic           done;
   logic           cfg_err;

   modport master (
      output cfg_wr, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_repeat,
      output start, abort, nco_valid,
      input  phi_inc_o, nco_clken, busy, done, cfg_err
   );

   modport slave (
      input  cfg_wr, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_repeat,
      input  start, abort, nco_valid,
      output phi_inc_o, nco_clken, busy, done, cfg_err
   );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep controller: steps an NCO phase increment from start to stop,
// holding each value for a programmable number of valid NCO samples.
//
//   state | meaning
//   IDLE  | waiting for start; cfg_wr accepted here only
//   PRIME | NCO clocked, waiting for first nco_valid (pipeline fill)
//   SWEEP | dwell counting on valid samples, stepping phi_inc_o
//   DONE  | one-cycle done pulse, NCO clock gated off
module nco_sweep_ctrl #(
   parameter int APR = 32,
   parameter int DWW = 16
) (
   input  logic           clk,
   input  logic           reset_n,
   nco_sweep_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_SWEEP = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t         r_state;
   logic [APR-1:0] r_start;
   logic [APR-1:0] r_stop;
   logic [APR-1:0] r_step;
   logic [DWW-1:0] r_dwell;
   logic           r_repeat;
   logic [DWW-1:0] r_cnt;
   logic [APR-1:0] r_phi;
   logic           r_clken;
   logic           r_done;
   logic           r_cfg_err;

   logic [APR:0]   w_sum;
   logic [APR-1:0] w_next_phi;
   logic [DWW-1:0] w_dwell_in;
   logic           w_cfg_ok;

   // Extra carry bit lets an overflowing step saturate to stop instead of wrapping.
   assign w_sum      = {1'b0, r_phi} + {1'b0, r_step};
   assign w_next_phi = (w_sum > {1'b0, r_stop}) ? r_stop : w_sum[APR-1:0];
   assign w_dwell_in = (bus.cfg_dwell == '0) ? DWW'(1) : bus.cfg_dwell;
   assign w_cfg_ok   = (bus.cfg_step != '0) && (bus.cfg_start <= bus.cfg_stop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_start   <= '0;
         r_stop    <= '0;
         r_step    <= APR'(1);
         r_dwell   <= DWW'(1);
         r_repeat  <= 1'b0;
         r_cnt     <= DWW'(1);
         r_phi     <= '0;
         r_clken   <= 1'b0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
         if (bus.abort) begin
            r_state <= ST_IDLE;
            r_clken <= 1'b0;
            r_phi   <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (bus.cfg_wr) begin
                     if (w_cfg_ok) begin
                        r_start  <= bus.cfg_start;
                        r_stop   <= bus.cfg_stop;
                        r_step   <= bus.cfg_step;
                        r_dwell  <= w_dwell_in;
                        r_repeat <= bus.cfg_repeat;
                     end else begin
                        r_cfg_err <= 1'b1;
                     end
                  end
                  if (bus.start) begin
                     r_phi   <= r_start;
                     r_clken <= 1'b1;
                     r_cnt   <= r_dwell;
                     r_state <= ST_PRIME;
                  end
               end
               ST_PRIME: begin
                  if (bus.cfg_wr) r_cfg_err <= 1'b1;
                  if (bus.nco_valid) r_state <= ST_SWEEP;
               end
               ST_SWEEP: begin
                  if (bus.cfg_wr) r_cfg_err <= 1'b1;
                  if (bus.nco_valid) begin
                     if (r_cnt == DWW'(1)) begin
                        if (r_phi < r_stop) begin
                           r_phi <= w_next_phi;
                           r_cnt <= r_dwell;
                        end else if (r_repeat) begin
                           r_phi <= r_start;
                           r_cnt <= r_dwell;
                        end else begin
                           r_state <= ST_DONE;
                           r_clken <= 1'b0;
                           r_done  <= 1'b1;
                        end
                     end else begin
                        r_cnt <= r_cnt - DWW'(1);
                     end
                  end
               end
               ST_DONE: begin
                  if (bus.cfg_wr) r_cfg_err <= 1'b1;
                  r_state <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.phi_inc_o = r_phi;
   assign bus.nco_clken = r_clken;
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.done      = r_done;
   assign bus.cfg_err   = r_cfg_err;

endmodule
